// File: rtl/spi_command_decoder.sv
// rtl/spi_command_decoder.sv - SPI byte command decoder driving a wrap-around event counter
module spi_command_decoder #(
  parameter int COUNT_WIDTH = 25,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce0,
  input  logic [7:0]             data_incoming,
  input  logic                   count_event,
  output logic [7:0]             data_outgoing,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   running,
  output logic                   byte_strobe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG  = 2'd1,
    ST_READ = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_LOAD  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h06;

  // ce0 synchronizer, history flop and registered rising-edge strobe
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ce0_hist_q, ce0_hist_d;
  logic                   byte_strobe_q, byte_strobe_d;

  // command decoder and counter state
  state_t                 state_q, state_d;
  logic [2:0]             arg_left_q, arg_left_d;
  logic                   arg_is_load_q, arg_is_load_d;
  logic [23:0]            arg_shift_q, arg_shift_d;
  logic [31:0]            snap_q, snap_d;
  logic [2:0]             read_left_q, read_left_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   running_q, running_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic [7:0]             dout_q, dout_d;

  // combinational helpers
  logic        event_inc;
  logic [32:0] count_wide;
  logic [32:0] ev_sum;
  logic [32:0] add_sum;
  logic        ev_wrap;
  logic        add_wrap;
  logic [31:0] operand;
  logic [31:0] count_ext;

  // Detect the 0->1 transition of the synchronized chip enable (end of a byte)
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], ce0};
    ce0_hist_d    = sync_q[SYNC_STAGES-1];
    byte_strobe_d = sync_q[SYNC_STAGES-1] & ~ce0_hist_q;
  end

  // Synchronizer flops idle high so leaving reset never looks like a byte end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      ce0_hist_q    <= 1'b1;
      byte_strobe_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      ce0_hist_q    <= ce0_hist_d;
      byte_strobe_q <= byte_strobe_d;
    end
  end

  // Next-state: background event counting, then opcode/operand/readback handling
  always_comb begin
    state_d       = state_q;
    arg_left_d    = arg_left_q;
    arg_is_load_d = arg_is_load_q;
    arg_shift_d   = arg_shift_q;
    snap_d        = snap_q;
    read_left_d   = read_left_q;
    count_d       = count_q;
    running_d     = running_q;
    ovf_d         = ovf_q;
    err_d         = err_q;
    dout_d        = dout_q;

    event_inc  = running_q & count_event;
    count_wide = 33'(count_q);
    ev_sum     = count_wide + 33'(event_inc);
    add_sum    = count_wide + 33'(data_incoming) + 33'(event_inc);
    ev_wrap    = (ev_sum >> COUNT_WIDTH) != 33'd0;
    add_wrap   = (add_sum >> COUNT_WIDTH) != 33'd0;
    operand    = {arg_shift_q, data_incoming};
    count_ext  = 32'(count_q);

    // Events count every cycle unless a command below overrides the update
    count_d = COUNT_WIDTH'(ev_sum);
    if (ev_wrap) begin
      ovf_d = 1'b1;
    end

    if (byte_strobe_q) begin
      unique case (state_q)
        ST_IDLE: begin
          case (data_incoming)
            OP_NOP: begin
            end
            OP_CLEAR: begin
              count_d = '0;
              ovf_d   = 1'b0;
              err_d   = 1'b0;
            end
            OP_START: running_d = 1'b1;
            OP_STOP:  running_d = 1'b0;
            OP_ADD: begin
              state_d       = ST_ARG;
              arg_left_d    = 3'd1;
              arg_is_load_d = 1'b0;
            end
            OP_LOAD: begin
              state_d       = ST_ARG;
              arg_left_d    = 3'd4;
              arg_is_load_d = 1'b1;
            end
            OP_READ: begin
              // Snapshot uses the pre-increment value; the event still counts
              state_d     = ST_READ;
              read_left_d = 3'd4;
              snap_d      = count_ext;
              dout_d      = count_ext[31:24];
            end
            default: err_d = 1'b1;
          endcase
        end
        ST_ARG: begin
          arg_shift_d = operand[23:0];
          arg_left_d  = arg_left_q - 3'd1;
          if (arg_left_q == 3'd1) begin
            state_d = ST_IDLE;
            if (arg_is_load_q) begin
              // LOAD wins over a same-cycle event, which is dropped
              count_d = COUNT_WIDTH'(operand);
              ovf_d   = ovf_q;
            end else begin
              count_d = COUNT_WIDTH'(add_sum);
              ovf_d   = ovf_q | add_wrap;
            end
          end
        end
        ST_READ: begin
          // Incoming bytes are dummies here; only the byte count matters
          if (read_left_q == 3'd1) begin
            state_d     = ST_IDLE;
            read_left_d = 3'd0;
          end else begin
            read_left_d = read_left_q - 3'd1;
            snap_d      = snap_q << 8;
            dout_d      = snap_d[31:24];
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Outside readback the master sees the post-command status
      if (state_d != ST_READ) begin
        dout_d = {running_d, ovf_d, err_d, 5'b0_0000};
      end
    end
  end

  // Decoder and counter registers; reset aborts any operand or readback frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      arg_left_q    <= 3'd0;
      arg_is_load_q <= 1'b0;
      arg_shift_q   <= '0;
      snap_q        <= '0;
      read_left_q   <= 3'd0;
      count_q       <= '0;
      running_q     <= 1'b0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      dout_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      arg_left_q    <= arg_left_d;
      arg_is_load_q <= arg_is_load_d;
      arg_shift_q   <= arg_shift_d;
      snap_q        <= snap_d;
      read_left_q   <= read_left_d;
      count_q       <= count_d;
      running_q     <= running_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
      dout_q        <= dout_d;
    end
  end

  assign data_outgoing = dout_q;
  assign count         = count_q;
  assign running       = running_q;
  assign byte_strobe   = byte_strobe_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
// tb/tb_spi_command_decoder.sv - directed self-checking bench for spi_command_decoder
module tb_spi_command_decoder;

  localparam int CW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce0;
  logic [7:0]    data_incoming;
  logic          count_event;
  logic [7:0]    data_outgoing;
  logic [CW-1:0] count;
  logic          running;
  logic          byte_strobe;

  int            checks = 0;
  int            errors = 0;
  int            strobe_cnt = 0;
  int            last_lat;
  logic [7:0]    resp;
  logic [7:0]    exp_rd [4];
  int            s0;

  spi_command_decoder #(.COUNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ce0           (ce0),
    .data_incoming (data_incoming),
    .count_event   (count_event),
    .data_outgoing (data_outgoing),
    .count         (count),
    .running       (running),
    .byte_strobe   (byte_strobe)
  );

  always #5 clk = ~clk;

  // Count every strobe seen by the bench
  always @(posedge clk) begin
    if (byte_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce0 = 1'b1;
    count_event = 1'b0;
    data_incoming = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One SPI byte: resp is what the master would shift in; ev pulses count_event in the strobe cycle
  task automatic spi_xfer(input logic [7:0] b, input bit ev, output logic [7:0] r);
    int  n;
    bit  seen;
    @(negedge clk);
    ce0 = 1'b0;
    r = data_outgoing;
    data_incoming = b;
    repeat (4) @(negedge clk);
    ce0 = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (byte_strobe) seen = 1'b1;
    end
    if (!seen) check("strobe_timeout", 32'(seen), 32'd1);
    last_lat = n;
    if (ev) count_event = 1'b1;
    @(negedge clk);
    count_event = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ce0 = 1'b1;
    data_incoming = 8'h00;
    count_event = 1'b0;

    // Reset state and absence of spurious strobes
    do_reset();
    @(negedge clk);
    check("rst_count", 32'(count), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_dout", 32'(data_outgoing), 32'h00);
    check("rst_strobe", 32'(byte_strobe), 32'h0);
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    check("idle_no_strobe", 32'(strobe_cnt), 32'(s0));

    // START then NOP returns status 0x80
    spi_xfer(8'h02, 1'b0, resp);
    check("strobe_latency_ok", 32'(last_lat >= 3 && last_lat <= 4), 32'd1);
    check("start_running", 32'(running), 32'h1);
    spi_xfer(8'h00, 1'b0, resp);
    check("status_after_start", 32'(resp), 32'h80);

    // ce0 held low produces no strobe until it rises
    s0 = strobe_cnt;
    @(negedge clk);
    ce0 = 1'b0;
    data_incoming = 8'h00;
    repeat (30) @(negedge clk);
    check("held_low_no_strobe", 32'(strobe_cnt), 32'(s0));
    ce0 = 1'b1;
    repeat (10) @(negedge clk);
    check("one_strobe_on_rise", 32'(strobe_cnt), 32'(s0 + 1));

    // LOAD then READ with illegal-looking dummies
    do_reset();
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h12, 1'b0, resp);
    spi_xfer(8'h34, 1'b0, resp);
    spi_xfer(8'h56, 1'b0, resp);
    check("load_count", 32'(count), 32'h0012_3456);
    spi_xfer(8'h06, 1'b0, resp);
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h12;
    exp_rd[2] = 8'h34;
    exp_rd[3] = 8'h56;
    for (int i = 0; i < 4; i++) begin
      spi_xfer(8'h7F, 1'b0, resp);
      check("read_byte", 32'(resp), 32'(exp_rd[i]));
    end
    check("read_end_dout", 32'(data_outgoing), 32'h00);
    spi_xfer(8'h00, 1'b0, resp);
    check("read_status", 32'(resp), 32'h00);

    // Wrap-around from all-ones via a counted event
    do_reset();
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'h01, 1'b0, resp);
    spi_xfer(8'hFF, 1'b0, resp);
    spi_xfer(8'hFF, 1'b0, resp);
    spi_xfer(8'hFF, 1'b0, resp);
    check("load_max", 32'(count), 32'h01FF_FFFF);
    spi_xfer(8'h02, 1'b0, resp);
    @(negedge clk);
    count_event = 1'b1;
    @(negedge clk);
    count_event = 1'b0;
    @(negedge clk);
    check("wrap_count", 32'(count), 32'h0);
    spi_xfer(8'h00, 1'b0, resp);
    check("wrap_status", 32'(data_outgoing), 32'hC0);
    spi_xfer(8'h01, 1'b0, resp);
    check("clear_status", 32'(data_outgoing), 32'h80);
    check("clear_count", 32'(count), 32'h0);

    // ADD with a simultaneous event
    do_reset();
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h0A, 1'b0, resp);
    spi_xfer(8'h02, 1'b0, resp);
    check("pre_add_count", 32'(count), 32'd10);
    spi_xfer(8'h04, 1'b0, resp);
    spi_xfer(8'h05, 1'b1, resp);
    check("add_event_count", 32'(count), 32'd16);

    // ADD plus event that wraps exactly to zero
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'h01, 1'b0, resp);
    spi_xfer(8'hFF, 1'b0, resp);
    spi_xfer(8'hFF, 1'b0, resp);
    spi_xfer(8'hFA, 1'b0, resp);
    spi_xfer(8'h04, 1'b0, resp);
    spi_xfer(8'h05, 1'b1, resp);
    check("add_wrap_count", 32'(count), 32'h0);
    check("add_wrap_status", 32'(data_outgoing), 32'hC0);

    // LOAD and CLEAR beat a same-cycle event; READ snapshots pre-increment
    spi_xfer(8'h01, 1'b0, resp);
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h00, 1'b0, resp);
    spi_xfer(8'h07, 1'b1, resp);
    check("load_drops_event", 32'(count), 32'd7);
    spi_xfer(8'h06, 1'b1, resp);
    check("read_event_counted", 32'(count), 32'd8);
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    exp_rd[2] = 8'h00;
    exp_rd[3] = 8'h07;
    for (int i = 0; i < 4; i++) begin
      spi_xfer(8'h00, 1'b0, resp);
      check("snap_byte", 32'(resp), 32'(exp_rd[i]));
    end
    spi_xfer(8'h01, 1'b1, resp);
    check("clear_drops_event", 32'(count), 32'd0);

    // Illegal opcode sets err, CLEAR removes it
    do_reset();
    spi_xfer(8'h7F, 1'b0, resp);
    check("err_status", 32'(data_outgoing), 32'h20);
    spi_xfer(8'h00, 1'b0, resp);
    check("err_sticky", 32'(data_outgoing), 32'h20);
    spi_xfer(8'h01, 1'b0, resp);
    check("err_cleared", 32'(data_outgoing), 32'h00);

    // Reset in the middle of a LOAD operand frame
    do_reset();
    spi_xfer(8'h05, 1'b0, resp);
    spi_xfer(8'hAA, 1'b0, resp);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    spi_xfer(8'h02, 1'b0, resp);
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_running", 32'(running), 32'h1);
    spi_xfer(8'h00, 1'b0, resp);
    check("midrst_status", 32'(resp), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_command_decoder.md
# spi_command_decoder

Byte-level command decoder between the `spi` slave and the event counter datapath. It runs in the `clk` domain and detects the end of each 8-bit SPI transaction from a synchronized `ce0`. It then interprets the received byte stream as opcodes plus operands, maintains a wrap-around event counter, and loads the next response byte onto `data_outgoing` for the `spi` block to shift out.

## Interface
- `COUNT_WIDTH`, 25: counter width, 1..32.
- `SYNC_STAGES`, 2: flip-flop stages in the `ce0` synchronizer, ≥2.

Ports:
- `clk` in 1: system clock. The only clock.
- `rst` in 1: synchronous, active-high reset.
- `ce0` in 1: SPI chip enable, active low, asynchronous to `clk`.
- `data_incoming` in 8: byte from `spi`. Stable from `ce0` rise until the next `ce0` fall.
- `count_event` in 1: event pulse, one count per `clk` cycle high.
- `data_outgoing` out 8: response byte. `spi` loads it at `ce0` fall.
- `count` out COUNT_WIDTH: current counter value.
- `running` out 1: counting of `count_event` is enabled.
- `byte_strobe` out 1: one-cycle pulse per completed SPI byte.

## Operation
- **Byte detection**
  - `ce0` passes through `SYNC_STAGES` flip-flops plus one history flop.
  - A 0→1 transition on the synchronized signal raises `byte_strobe` for exactly one cycle.
  - `data_incoming` is sampled in that cycle.
- **FSM states: IDLE, ARG, READ**
  - IDLE: the sampled byte is an opcode.
  - ARG: collects `arg_left` operand bytes, MSB first, into a 32-bit shift register.
  - READ: shifts out a 32-bit snapshot.
- **Opcodes** (sampled in IDLE):
  - 0x00 NOP: no action.
  - 0x01 CLEAR: `count`=0, `ovf`=0, `err`=0.
  - 0x02 START: `running`=1.
  - 0x03 STOP: `running`=0.
  - 0x04 ADD: go to ARG with 1 byte. On that byte, `count += byte`.
  - 0x05 LOAD: go to ARG with 4 bytes. On the 4th byte, `count` = operand[COUNT_WIDTH-1:0].
  - 0x06 READ: snapshot = zero-extended `count` at execution. `data_outgoing` = snapshot[31:24]; go to READ with 4 bytes left.
  - Any other opcode: `err`=1, stay in IDLE.
- **READ state**
  - Each strobe decrements the remaining-byte count and presents the next snapshot byte, MSB first.
  - The strobe that ends the 4th byte returns to IDLE and presents the status byte.
  - `data_incoming` is ignored in READ.
- **Status byte**, presented in IDLE and ARG: {`running`, `ovf`, `err`, 5'b0}.
- **Arithmetic and wrap-around**
  - All updates are modulo 2^COUNT_WIDTH.
  - Any wrap sets sticky `ovf`.
  - With `running`=1, each cycle with `count_event`=1 adds 1.
- **Simultaneous events**
  - ADD and an event in the same cycle: `count += byte + 1`. `ovf` is set if the combined sum wraps.
  - LOAD or CLEAR and an event in the same cycle: LOAD/CLEAR wins and the event is dropped.
  - READ snapshot and an event in the same cycle: the snapshot takes the pre-increment value.
- **Reset**
  - Values: `count`=0, `running`=0, `ovf`=0, `err`=0, state=IDLE, `data_outgoing`=0x00, `byte_strobe`=0.
  - Synchronizer flops reset to 1 (bus idle), so reset never produces a spurious strobe.
  - Reset mid-frame aborts ARG/READ. The next completed byte is treated as an opcode.

## Timing
- **`byte_strobe` latency**: asserts SYNC_STAGES+1 to SYNC_STAGES+2 `clk` edges after `ce0` rises (3–4 cycles at default).
- **Command execution**
  - Updates are registered on the `clk` edge ending the `byte_strobe` cycle.
  - `count`, `running` and `data_outgoing` are valid on the next cycle.
- **Master spacing requirement**: `ce0` must stay high ≥ SYNC_STAGES+3 `clk` cycles between bytes so `data_outgoing` is stable before the next `ce0` fall. Shorter gaps are unsupported.
- **Response pipeline**: the response to byte N is shifted out during transaction N+1 (one-transaction pipeline).
- **Event counting**: an event is counted in the cycle after `count_event` is sampled high. Back-to-back events count every cycle.
- **Held `ce0`**: `ce0` held low or high indefinitely produces no strobes.

## Test plan
- **Reset and status**: reset, then send 0x02 and 0x00. Required: `running`=1 after the first strobe; the byte returned during the second transaction is 0x80.
- **LOAD and READ**
  - Send 0x05,0x00,0x12,0x34,0x56 → `count`=0x123456.
  - Then send 0x06 plus 4 dummy bytes. Required: returned bytes are 0x00,0x12,0x34,0x56, followed by status 0x00.
- **Wrap-around**: LOAD 0x01FFFFFF, START, pulse `count_event` 1 cycle. Required: `count`=0, status 0xC0. CLEAR then gives status 0x80 (`running` still 1).
- **ADD with a simultaneous event**: `count`=10, running. Hold `count_event` high during the strobe of ADD operand 0x05. Required: `count`=16 one cycle later.
- **Illegal opcode**: send 0x7F → `err`=1, status 0x20, state IDLE. The next byte 0x01 clears `err`.
- **Reset mid-frame**: send 0x05,0xAA, assert `rst` for 1 cycle, then send 0x02. Required: `count`=0, `running`=1 (0x02 is decoded as an opcode).
